mul_rep_add: RTL and testbench
==============================

MUL_REP_ADD -- requirements
Module: mul_rep_add

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports as follows.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clr  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 data_in  input  16  shared operand bus: operand A on the start cycle, operand B on the following cycle.
REQ-006 product  output  32  unsigned A*B; holds its value until the next accepted start.
REQ-007 busy  output  1  high in LOADB, CHECK and ADD.
REQ-008 done  output  1  high for exactly one cycle, in DONE.

Function
REQ-009 The block SHALL multiply by repeated addition, as the inverse companion of the repeated-subtraction divider; all arithmetic is unsigned.
REQ-010 The FSM SHALL have five states: IDLE, LOADB, CHECK, ADD, DONE; busy and done are decoded from the state register only (Moore).
REQ-011 IDLE: start=1 at edge E0 -> register A<=data_in, go to LOADB; start=0 -> stay in IDLE.
REQ-012 LOADB: at edge E1, B<=data_in, product<=0, go to CHECK; data_in is not sampled in any other state.
REQ-013 CHECK: at edge E2, if A==0 or B==0 -> go to DONE with product=0.
REQ-014 CHECK, otherwise: at edge E2, cnt<=min(A,B), addend<=max(A,B), go to ADD; A==B SHALL load cnt=A.
REQ-015 ADD, each edge: product<=product+addend (zero-extended to 32 bits), cnt<=cnt-1.
REQ-016 ADD: when cnt==1 before the edge, the same edge SHALL perform the last add and go to DONE.
REQ-017 With m=min(A,B), DONE SHALL be entered at edge E(2+m) for every m, including m=0.
REQ-018 DONE: done=1 and busy=0 for one cycle, then unconditionally go to IDLE.
REQ-019 start SHALL be ignored in LOADB, CHECK, ADD and DONE, with no effect on state or data.
REQ-020 A start in the cycle right after DONE (IDLE) SHALL be accepted normally; back-to-back operations are legal.
REQ-021 The product SHALL never overflow: the maximum is 0xFFFE0001 and it fits in 32 bits.
REQ-022 product SHALL change only at E1 (cleared to 0) and in ADD cycles; it stays stable in IDLE and DONE.
REQ-023 cnt SHALL never wrap below 0; ADD is never entered with cnt==0.

Reset
REQ-024 clr=1 at any edge SHALL force state=IDLE, product=0, A=B=cnt=addend=0, busy=0, done=0; clr has priority over start.
REQ-025 clr in any state, including mid-ADD and DONE, SHALL abort the operation; no done pulse is produced for the aborted operation.
REQ-026 After clr deasserts, a start at the next edge SHALL be accepted.

Verification
REQ-027 A=7, B=5 -> swap gives cnt=5, addend=7; product=35; done high in the single cycle after E7; busy high from after E0 until E7.
REQ-028 A=0, B=0x1234 -> no ADD cycles; done after E2; product=0.
REQ-029 A=3, B=1000 -> exactly 3 ADD cycles thanks to the swap; product=3000; done after E5.
REQ-030 A=B=0xFFFF -> product=0xFFFE0001; done after E65537.
REQ-031 start pulsed during ADD with different data_in -> ignored; result matches the original operands; then a new start in the IDLE cycle after DONE yields the new product.
REQ-032 clr during the 3rd ADD cycle of 7*5 -> next cycle shows IDLE, product=0, busy=0, done=0; no later done pulse; a following start with A=2, B=2 gives product=4.

Source files
------------

// File: rtl/mul_rep_add_if.sv
// Operand/result bundle for the repeated-addition multiplier.
// master drives requests, slave (the multiplier) returns results.
interface mul_rep_add_if;
  logic        start;
  logic [15:0] data_in;
  logic [31:0] product;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output data_in,
    input  product,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  data_in,
    output product,
    output busy,
    output done
  );
endinterface

// File: rtl/mul_rep_add.sv
// Unsigned 16x16 multiplier by repeated addition.
// Operands share data_in: A on the start cycle, B on the next.
module mul_rep_add (
  input  logic          clk,
  input  logic          clr,
  mul_rep_add_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADB,
    S_CHECK,
    S_ADD,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] addend_q, addend_d;
  logic [31:0] product_q, product_d;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    addend_d  = addend_q;
    product_d = product_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.data_in;
          state_d = S_LOADB;
        end
      end
      S_LOADB: begin
        b_d       = bus.data_in;
        product_d = 32'd0;
        state_d   = S_CHECK;
      end
      S_CHECK: begin
        if (a_q == 16'd0 || b_q == 16'd0) begin
          state_d = S_DONE;
        end else begin
          // Count down the smaller operand to bound the add loop.
          if (a_q <= b_q) begin
            cnt_d    = a_q;
            addend_d = b_q;
          end else begin
            cnt_d    = b_q;
            addend_d = a_q;
          end
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        product_d = product_q + {16'd0, addend_q};
        cnt_d     = cnt_q - 16'd1;
        if (cnt_q == 16'd1) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      a_q       <= 16'd0;
      b_q       <= 16'd0;
      cnt_q     <= 16'd0;
      addend_q  <= 16'd0;
      product_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      addend_q  <= addend_d;
      product_q <= product_d;
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = (state_q == S_LOADB) ||
                       (state_q == S_CHECK) ||
                       (state_q == S_ADD);
  assign bus.done    = (state_q == S_DONE);

endmodule

// File: tb/tb_mul_rep_add.sv
// Directed and randomized checks of mul_rep_add against
// an arithmetic reference (product = A*B, done at E(2+min)).
module tb_mul_rep_add;

  logic clk;
  logic clr;
  int   nassert;
  int   nfail;
  logic [31:0] last_prod;

  mul_rep_add_if bus ();

  mul_rep_add dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation; inject>0 pulses start with junk data at that edge index.
  task automatic run_op(input logic [15:0] a,
                        input logic [15:0] b,
                        input int inject);
    int k;
    int m;
    int exp_k;
    bit busy_ok;
    bit seen;
    logic [31:0] exp_p;
    m     = (a < b) ? int'(a) : int'(b);
    exp_k = 2 + m;
    exp_p = 32'(a) * 32'(b);
    @(negedge clk);
    chk("idle_done", {31'd0, bus.done}, 32'd0);
    chk("idle_prod", bus.product, last_prod);
    bus.start   = 1'b1;
    bus.data_in = a;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = b;
    @(posedge clk);
    @(negedge clk);
    chk("e1_prod", bus.product, 32'd0);
    k       = 1;
    busy_ok = 1'b1;
    seen    = 1'b0;
    while (k < 70000 && !seen) begin
      if (!bus.busy || bus.done) busy_ok = 1'b0;
      bus.start   = (inject > 0 && k == inject);
      bus.data_in = 16'($urandom);
      @(posedge clk);
      k++;
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("done_edge", 32'(k), 32'(exp_k));
    chk("busy_span", {31'd0, busy_ok}, 32'd1);
    chk("done_busy", {31'd0, bus.busy}, 32'd0);
    chk("product", bus.product, exp_p);
    last_prod = exp_p;
  endtask

  initial begin
    int k;
    bit ghost;
    logic [15:0] ra;
    logic [15:0] rb;
    nassert     = 0;
    nfail       = 0;
    last_prod   = 32'd0;
    clr         = 1'b1;
    bus.start   = 1'b1;
    bus.data_in = 16'h00AA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_prod", bus.product, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    clr       = 1'b0;
    bus.start = 1'b0;

    run_op(16'd7, 16'd5, 0);
    run_op(16'd0, 16'h1234, 0);
    run_op(16'd3, 16'd1000, 0);
    run_op(16'h1234, 16'd0, 0);
    run_op(16'd9, 16'd9, 0);
    run_op(16'd1, 16'hFFFF, 0);
    run_op(16'd6, 16'd11, 3);
    run_op(16'd4, 16'd8, 0);

    for (int i = 0; i < 8; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) run_op(ra, rb, 0);
      else run_op(rb, ra, 4);
    end

    run_op(16'hFFFF, 16'hFFFF, 0);

    // Abort 7*5 during its third ADD cycle.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 16'd7;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.data_in = 16'd5;
    repeat (4) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk("abort_prod", bus.product, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    ghost = 1'b0;
    for (k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) ghost = 1'b1;
    end
    chk("abort_quiet", {31'd0, ghost}, 32'd0);
    last_prod = 32'd0;
    run_op(16'd2, 16'd2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
